mjb_input_frontend: RTL and testbench



---
 rtl/mjb_pkg.sv | 28 ++
 rtl/btn_debounce.sv | 40 ++++
 rtl/mjb_input_frontend.sv | 88 ++++++++
 tb/tb_mjb_input_frontend.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mjb_pkg.sv
// rtl/mjb_pkg.sv - choice codes, round state type and press encoder for the input frontend
package mjb_pkg;

   localparam logic [1:0] CH_NONE    = 2'b00;
   localparam logic [1:0] CH_ROCK    = 2'b01;
   localparam logic [1:0] CH_SCISSOR = 2'b10;
   localparam logic [1:0] CH_PAPER   = 2'b11;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      READY   = 2'd2
   } state_t;

   // press is {P,S,R}, active-high; anything that is not one-hot maps to none
   function automatic logic [1:0] encode_press(input logic [2:0] press);
      logic [1:0] ch;
      ch = CH_NONE;
      case (press)
         3'b001:  ch = CH_ROCK;
         3'b010:  ch = CH_SCISSOR;
         3'b100:  ch = CH_PAPER;
         default: ch = CH_NONE;
      endcase
      return ch;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser and stable-count debouncer for one active-low button
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic ck,
   input  logic reset_n,
   input  logic raw_n,
   output logic level_n
);

   localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

   logic             sync1_n;
   logic             sync2_n;
   logic [CNT_W-1:0] cnt;

   // level flips on the first disagreeing sample after the counter has seen
   // DEBOUNCE_CYCLES disagreeing samples in a row
   always_ff @(posedge ck or negedge reset_n) begin
      if (!reset_n) begin
         sync1_n <= 1'b1;
         sync2_n <= 1'b1;
         level_n <= 1'b1;
         cnt     <= '0;
      end else begin
         sync1_n <= raw_n;
         sync2_n <= sync1_n;
         if (sync2_n == level_n) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            level_n <= sync2_n;
            cnt     <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/mjb_input_frontend.sv
// rtl/mjb_input_frontend.sv - debounces six hand buttons, latches one choice per player, hands both to the core
module mjb_input_frontend
   import mjb_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic       ck,
   input  logic       reset_n,
   input  logic [5:0] raw_n,
   input  logic       arm,
   input  logic       take,
   output logic [1:0] p1_choice,
   output logic [1:0] p2_choice,
   output logic       valid,
   output logic [1:0] conflict
);

   logic [5:0]      level_n;
   logic [1:0][2:0] press;
   logic [1:0][1:0] choice;
   logic [1:0]      rel_seen;
   logic [1:0]      released;
   logic [1:0]      one_hot;
   logic [1:0]      multi;
   logic [1:0]      cap_now;
   logic [1:0]      captured_next;
   state_t          state;

   for (genvar i = 0; i < 6; i++) begin : g_line
      btn_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce (
         .ck      (ck),
         .reset_n (reset_n),
         .raw_n   (raw_n[i]),
         .level_n (level_n[i])
      );
   end

   assign press = ~level_n;

   // arm low outranks capture, so a capture edge needs arm as well as COLLECT
   for (genvar p = 0; p < 2; p++) begin : g_player
      assign released[p]      = (press[p] == 3'b000);
      assign one_hot[p]       = $onehot(press[p]);
      assign multi[p]         = !one_hot[p] && !released[p];
      assign cap_now[p]       = arm && (state == COLLECT) && (choice[p] == CH_NONE)
                                && one_hot[p] && rel_seen[p];
      assign captured_next[p] = (choice[p] != CH_NONE) || cap_now[p];
   end

   always_ff @(posedge ck or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         choice   <= '0;
         rel_seen <= 2'b11;
         conflict <= 2'b00;
      end else begin
         rel_seen <= (rel_seen & ~cap_now) | released;
         conflict <= (conflict | multi) & ~released;
         if (!arm) begin
            state  <= IDLE;
            choice <= '0;
         end else begin
            case (state)
               IDLE: state <= COLLECT;
               COLLECT: begin
                  if (cap_now[0]) choice[0] <= encode_press(press[0]);
                  if (cap_now[1]) choice[1] <= encode_press(press[1]);
                  if (&captured_next) state <= READY;
               end
               READY: begin
                  if (take) begin
                     state  <= COLLECT;
                     choice <= '0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign p1_choice = choice[0];
   assign p2_choice = choice[1];
   assign valid     = (state == READY);

endmodule

// File: tb/tb_mjb_input_frontend.sv
// tb/tb_mjb_input_frontend.sv - randomized and directed bench for mjb_input_frontend against a behavioural model
module tb_mjb_input_frontend;

   localparam int DB = 4;

   logic       ck = 1'b0;
   logic       reset_n;
   logic [5:0] raw_n;
   logic       arm;
   logic       take;
   logic [1:0] p1_choice;
   logic [1:0] p2_choice;
   logic       valid;
   logic [1:0] conflict;

   mjb_input_frontend #(
      .DEBOUNCE_CYCLES (DB)
   ) dut (
      .ck        (ck),
      .reset_n   (reset_n),
      .raw_n     (raw_n),
      .arm       (arm),
      .take      (take),
      .p1_choice (p1_choice),
      .p2_choice (p2_choice),
      .valid     (valid),
      .conflict  (conflict)
   );

   always #5 ck = ~ck;

   int n_checks = 0;
   int n_fail   = 0;

   // model: debounced levels, raw delayed two edges, sample windows, round status
   logic [5:0]  m_lvl;
   logic [5:0]  raw_d1;
   logic [5:0]  raw_d2;
   logic [31:0] win [6];
   int          m_phase;
   logic [1:0]  m_ch [2];
   bit          m_rel [2];
   bit          m_conf [2];

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_lvl  = '1;
      raw_d1 = '1;
      raw_d2 = '1;
      for (int i = 0; i < 6; i++) win[i] = '1;
      m_phase = 0;
      for (int p = 0; p < 2; p++) begin
         m_ch[p]   = 2'b00;
         m_rel[p]  = 1'b1;
         m_conf[p] = 1'b0;
      end
   endtask

   task automatic model_edge();
      logic [5:0] samp;
      logic [2:0] pv;
      int         n;
      bit         cap [2];
      logic [1:0] nc [2];
      int         mask;
      mask   = (1 << (DB + 1)) - 1;
      samp   = raw_d2;
      raw_d2 = raw_d1;
      raw_d1 = raw_n;
      for (int p = 0; p < 2; p++) begin
         pv     = ~m_lvl[3*p +: 3];
         n      = $countones(pv);
         cap[p] = arm && (m_phase == 1) && (m_ch[p] == 2'b00) && (n == 1) && m_rel[p];
         nc[p]  = (pv == 3'b001) ? 2'd1 : (pv == 3'b010) ? 2'd2 : 2'd3;
         if (cap[p]) m_rel[p] = 1'b0;
         else if (n == 0) m_rel[p] = 1'b1;
         if (n >= 2) m_conf[p] = 1'b1;
         else if (n == 0) m_conf[p] = 1'b0;
      end
      if (!arm) begin
         m_phase = 0;
         m_ch[0] = 2'b00;
         m_ch[1] = 2'b00;
      end else if (m_phase == 0) begin
         m_phase = 1;
      end else if (m_phase == 1) begin
         for (int p = 0; p < 2; p++) if (cap[p]) m_ch[p] = nc[p];
         if (m_ch[0] != 2'b00 && m_ch[1] != 2'b00) m_phase = 2;
      end else if (take) begin
         m_phase = 1;
         m_ch[0] = 2'b00;
         m_ch[1] = 2'b00;
      end
      // a level flips once the last DB+1 synchronised samples all disagree with it
      for (int i = 0; i < 6; i++) begin
         win[i] = {win[i][30:0], samp[i]};
         if (m_lvl[i] ? ((win[i] & mask) == 0) : ((win[i] & mask) == mask))
            m_lvl[i] = ~m_lvl[i];
      end
   endtask

   task automatic step();
      @(posedge ck);
      model_edge();
      #1;
      check_val("p1_choice", int'(p1_choice), int'(m_ch[0]));
      check_val("p2_choice", int'(p2_choice), int'(m_ch[1]));
      check_val("valid", int'(valid), (m_phase == 2) ? 1 : 0);
      check_val("conflict", int'(conflict), int'({m_conf[1], m_conf[0]}));
   endtask

   task automatic steps(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic do_reset_async();
      reset_n = 1'b0;
      #1;
      check_val("rst_p1", int'(p1_choice), 0);
      check_val("rst_p2", int'(p2_choice), 0);
      check_val("rst_valid", int'(valid), 0);
      check_val("rst_conflict", int'(conflict), 0);
      model_reset();
      repeat (2) @(posedge ck);
      #1;
      reset_n = 1'b1;
   endtask

   function automatic logic [2:0] rand_group();
      int         r;
      logic [2:0] g;
      r = $urandom_range(0, 9);
      g = 3'b111;
      if (r >= 4 && r < 8) begin
         case ($urandom_range(0, 2))
            0:       g = 3'b110;
            1:       g = 3'b101;
            default: g = 3'b011;
         endcase
      end else if (r == 8) begin
         case ($urandom_range(0, 2))
            0:       g = 3'b100;
            1:       g = 3'b010;
            default: g = 3'b001;
         endcase
      end else if (r == 9) begin
         g = 3'b000;
      end
      return g;
   endfunction

   initial begin
      int len;
      reset_n = 1'b1;
      raw_n   = '1;
      arm     = 1'b0;
      take    = 1'b0;
      #2;
      do_reset_async();

      // R1 and P2 held from edge 0: valid exactly at edge 3+DB
      arm   = 1'b1;
      raw_n = 6'b011110;
      for (int e = 0; e < 8; e++) begin
         step();
         if (e == 6) check_val("s1_valid_e6", int'(valid), 0);
         if (e == 7) begin
            check_val("s1_valid_e7", int'(valid), 1);
            check_val("s1_p1_rock", int'(p1_choice), 1);
            check_val("s1_p2_paper", int'(p2_choice), 3);
         end
      end

      // take while R1 stays held: round clears, no re-capture from the held button
      take  = 1'b1;
      raw_n = 6'b111110;
      step();
      take = 1'b0;
      check_val("take_valid", int'(valid), 0);
      check_val("take_p1", int'(p1_choice), 0);
      check_val("take_p2", int'(p2_choice), 0);
      steps(20);
      check_val("hold_no_recap", int'(p1_choice), 0);

      // 3-cycle glitch on S1 never reaches the debounced level
      raw_n = '1;
      steps(10);
      raw_n = 6'b111101;
      steps(3);
      raw_n = '1;
      steps(12);
      check_val("glitch_p1", int'(p1_choice), 0);

      raw_n = 6'b111110;
      steps(10);
      check_val("recap_p1", int'(p1_choice), 1);

      // P2 double press flags conflict without capturing
      raw_n = 6'b100110;
      steps(10);
      check_val("multi_conflict", int'(conflict), 2);
      check_val("multi_p2", int'(p2_choice), 0);
      raw_n = 6'b111110;
      steps(10);
      check_val("multi_cleared", int'(conflict), 0);

      // drop arm with P1 captured, re-arm: held R1 must not re-capture
      arm = 1'b0;
      step();
      check_val("armdrop_p1", int'(p1_choice), 0);
      arm = 1'b1;
      steps(10);
      check_val("rearm_no_recap", int'(p1_choice), 0);

      raw_n = 6'b101110;
      steps(10);
      check_val("s2_alone", int'(p2_choice), 2);
      check_val("s2_not_valid", int'(valid), 0);
      raw_n = 6'b101111;
      steps(10);
      raw_n = 6'b101110;
      steps(10);
      check_val("ready_valid", int'(valid), 1);

      // asynchronous reset in the middle of READY
      #3;
      do_reset_async();

      for (int blk = 0; blk < 400; blk++) begin
         raw_n = {rand_group(), rand_group()};
         arm   = ($urandom_range(0, 19) != 0);
         len   = $urandom_range(1, 12);
         for (int k = 0; k < len; k++) begin
            take = ($urandom_range(0, 3) == 0);
            step();
         end
      end
      take = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
